// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if
//   Groups the bit-stream, configuration and display signals of the
//   programmable sequence detector.
//   master : drives en, bit_in, bit_valid, load, pat_in, len_in, overlap,
//            clr_cnt; observes match, hit_count, seg.
//   slave  : the detector side (the reverse directions).
interface seq_detector_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               bit_in;
  logic               bit_valid;
  logic               load;
  logic [MAX_LEN-1:0] pat_in;
  logic [LEN_W-1:0]   len_in;
  logic               overlap;
  logic               clr_cnt;
  logic               match;
  logic [CNT_W-1:0]   hit_count;
  logic [7:0]         seg;

  modport master (
    output en, bit_in, bit_valid, load, pat_in, len_in, overlap, clr_cnt,
    input  match, hit_count, seg
  );

  modport slave (
    input  en, bit_in, bit_valid, load, pat_in, len_in, overlap, clr_cnt,
    output match, hit_count, seg
  );
endinterface

// File: rtl/seq_detector_prog.sv
// seq_detector_prog
//   Detects a runtime-programmable serial pattern (1..MAX_LEN bits) in a
//   qualified bit stream, in overlapping or restart-after-hit mode. Hits are
//   counted in a saturating counter whose value mod 10 is shown on a
//   7-segment digit, with a sticky decimal point set by any hit.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active HIGH despite its name
//   bus   : seq_detector_prog_if.slave (stream, config, match/count/seg)
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input logic                clk,
  input logic                rst_n,
  seq_detector_prog_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] pat_reg;
  logic [MAX_LEN-1:0] hist_reg;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len_clamped;
  logic               match_reg;
  logic               dp_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               accept;
  logic               hit;
  logic [3:0]         digit;
  logic [6:0]         seg_digit;

  // Bit gi takes part in the compare only when it lies below the length.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  always_comb begin
    // load takes priority, so a coincident bit is simply dropped
    accept    = bus.en && bus.bit_valid && !bus.load;
    hist_next = (hist_reg << 1) | MAX_LEN'(bus.bit_in);
    fill_next = (fill_reg >= MAX_LEN_W) ? MAX_LEN_W : fill_reg + 1'b1;
    hit       = accept && (fill_next >= len_reg) &&
                (((hist_next ^ pat_reg) & len_mask) == '0);

    len_clamped = bus.len_in;
    if (bus.len_in == '0) begin
      len_clamped = LEN_W'(1);
    end else if (bus.len_in > MAX_LEN_W) begin
      len_clamped = MAX_LEN_W;
    end
  end

  // Pattern configuration and shift history
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pat_reg   <= '0;
      len_reg   <= MAX_LEN_W;
      hist_reg  <= '0;
      fill_reg  <= '0;
      match_reg <= 1'b0;
    end else if (bus.load) begin
      pat_reg   <= bus.pat_in;
      len_reg   <= len_clamped;
      hist_reg  <= '0;
      fill_reg  <= '0;
      match_reg <= 1'b0;
    end else if (accept) begin
      hist_reg  <= hist_next;
      // In non-overlap mode a hit empties the fill so the next hit needs
      // a full fresh pattern.
      fill_reg  <= (hit && !bus.overlap) ? '0 : fill_next;
      match_reg <= hit;
    end else begin
      match_reg <= 1'b0;
    end
  end

  // Hit counter and sticky decimal point; a clear beats a coincident hit.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_reg <= '0;
      dp_reg  <= 1'b0;
    end else if (bus.en && bus.clr_cnt) begin
      cnt_reg <= '0;
      dp_reg  <= 1'b0;
    end else if (hit) begin
      if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      dp_reg <= 1'b1;
    end
  end

  // 7-segment decode of the count's last decimal digit, {g,f,e,d,c,b,a}
  always_comb begin
    digit = 4'(cnt_reg % CNT_W'(10));
    case (digit)
      4'd0:    seg_digit = 7'b0111111;
      4'd1:    seg_digit = 7'b0000110;
      4'd2:    seg_digit = 7'b1011011;
      4'd3:    seg_digit = 7'b1001111;
      4'd4:    seg_digit = 7'b1100110;
      4'd5:    seg_digit = 7'b1101101;
      4'd6:    seg_digit = 7'b1111101;
      4'd7:    seg_digit = 7'b0000111;
      4'd8:    seg_digit = 7'b1111111;
      4'd9:    seg_digit = 7'b1101111;
      default: seg_digit = 7'b0000000;
    endcase
  end

  assign bus.match     = match_reg;
  assign bus.hit_count = cnt_reg;
  assign bus.seg       = {dp_reg, seg_digit};

endmodule
